// File: rtl/ksa_sub_pipe.sv
// ksa_sub_pipe: three-stage pipelined Kogge-Stone subtractor.
// Computes D = A - B - Bi as A + ~B + ~Bi through a radix-2 parallel-prefix
// carry network, with borrow-out and signed-overflow flags. The prefix
// levels are split across stages 2 and 3. A single global advance signal
// moves every stage at once, and valid/ready handshakes sit on both sides.
module ksa_sub_pipe #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bi,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] D,
  output logic         Bo,
  output logic         V
);

  // Prefix depth. Stage 2 takes the first ceil(L/2) levels and stage 3
  // takes the rest. Stage 3 always gets at least one level for N >= 8.
  localparam int L      = $clog2(N);
  localparam int L_S2   = (L + 1) / 2;
  localparam int D_LAST = 1 << (L - 1);

  // Group generate/propagate vectors carried between prefix levels.
  typedef struct packed {
    logic [N-1:0] g;
    logic [N-1:0] p;
  } gp_t;

  // One Kogge-Stone level k (span 2^(k-1)): every bit combines with the
  // bit one span below it. Bits below the span pass through unchanged.
  function automatic gp_t ks_level(input gp_t x, input int k);
    gp_t y;
    int  span;
    span = 1 << (k - 1);
    y    = x;
    for (int i = 0; i < N; i++) begin
      if (i >= span) begin
        y.g[i] = x.g[i] | (x.p[i] & x.g[i-span]);
        y.p[i] = x.p[i] & x.p[i-span];
      end
    end
    return y;
  endfunction

  // ---------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------
  // Stage 1: bitwise generate/propagate of A + ~B, carry-in, operand sign bits.
  logic         v1_q,  v1_d;
  logic [N-1:0] g1_q,  g1_d;
  logic [N-1:0] p1_q,  p1_d;
  logic         c1_q,  c1_d;
  logic         am1_q, am1_d;
  logic         bm1_q, bm1_d;

  // Stage 2: partially resolved group G/P, plus the values the sum needs.
  logic         v2_q,  v2_d;
  gp_t          gp2_q, gp2_d;
  logic [N-1:0] p2_q,  p2_d;
  logic         c2_q,  c2_d;
  logic         am2_q, am2_d;
  logic         bm2_q, bm2_d;

  // Stage 3: final result registers, which drive the outputs directly.
  logic         v3_q,  v3_d;
  logic [N-1:0] d3_q,  d3_d;
  logic         bo3_q, bo3_d;
  logic         ov3_q, ov3_d;

  logic         adv;

  // ---------------------------------------------------------------------
  // Datapath combinational logic
  // ---------------------------------------------------------------------
  gp_t          s2_gp;
  gp_t          s3_gp;
  logic [N-1:0] s3_g;
  logic [N-1:0] s3_carry;
  logic [N-1:0] s3_sum;
  logic         s3_bo;
  logic         s3_ov;

  // Stage-2 network: fold the carry-in into bit 0, then run the first
  // ceil(L/2) levels. After that fold, G[i] is the carry out of bit i.
  always_comb begin
    s2_gp      = '{g: g1_q, p: p1_q};
    s2_gp.g[0] = g1_q[0] | (p1_q[0] & c1_q);
    for (int k = 1; k <= L_S2; k++) begin
      s2_gp = ks_level(s2_gp, k);
    end
  end

  // Stage-3 network: remaining levels, then the sum XOR and the flags.
  // The last level only needs G, so it is written out inline.
  always_comb begin
    s3_gp = gp2_q;
    for (int k = L_S2 + 1; k < L; k++) begin
      s3_gp = ks_level(s3_gp, k);
    end
    s3_g = s3_gp.g;
    for (int i = D_LAST; i < N; i++) begin
      s3_g[i] = s3_gp.g[i] | (s3_gp.p[i] & s3_gp.g[i-D_LAST]);
    end
    s3_carry = {s3_g[N-2:0], c2_q};
    s3_sum   = p2_q ^ s3_carry;
    s3_bo    = ~s3_g[N-1];
    s3_ov    = (am2_q ^ bm2_q) & (am2_q ^ s3_sum[N-1]);
  end

  // ---------------------------------------------------------------------
  // Global advance and next-state selection
  // ---------------------------------------------------------------------
  assign adv      = ~v3_q | out_ready;
  assign in_ready = adv;

  // Every stage loads its upstream value on advance and holds otherwise.
  always_comb begin
    // NOTE: each _d gets a hold value before the conditional load, so no
    // path leaves a combinational output unassigned and no latch is inferred.
    v1_d  = v1_q;  g1_d  = g1_q;  p1_d  = p1_q;  c1_d  = c1_q;
    am1_d = am1_q; bm1_d = bm1_q;
    v2_d  = v2_q;  gp2_d = gp2_q; p2_d  = p2_q;  c2_d  = c2_q;
    am2_d = am2_q; bm2_d = bm2_q;
    v3_d  = v3_q;  d3_d  = d3_q;  bo3_d = bo3_q; ov3_d = ov3_q;
    if (adv) begin
      v1_d  = in_valid;
      g1_d  = A & ~B;
      p1_d  = A ^ ~B;
      c1_d  = ~Bi;
      am1_d = A[N-1];
      bm1_d = B[N-1];

      v2_d  = v1_q;
      gp2_d = s2_gp;
      p2_d  = p1_q;
      c2_d  = c1_q;
      am2_d = am1_q;
      bm2_d = bm1_q;

      v3_d  = v2_q;
      d3_d  = s3_sum;
      bo3_d = s3_bo;
      ov3_d = s3_ov;
    end
  end

  // Pipeline registers with asynchronous clear of valid bits and data.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: data registers are cleared along with the valid bits so that
    // D/Bo/V read as zero during and right after reset. These are plain
    // flops, not a memory array, so the clear costs no RAM inference.
    if (!rst_n) begin
      v1_q  <= 1'b0; g1_q  <= '0; p1_q  <= '0; c1_q  <= 1'b0;
      am1_q <= 1'b0; bm1_q <= 1'b0;
      v2_q  <= 1'b0; gp2_q <= '0; p2_q  <= '0; c2_q  <= 1'b0;
      am2_q <= 1'b0; bm2_q <= 1'b0;
      v3_q  <= 1'b0; d3_q  <= '0; bo3_q <= 1'b0; ov3_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates let every stage sample the pre-edge
      // value of the stage before it, which is what makes this a shift.
      v1_q  <= v1_d;  g1_q  <= g1_d;  p1_q  <= p1_d;  c1_q  <= c1_d;
      am1_q <= am1_d; bm1_q <= bm1_d;
      v2_q  <= v2_d;  gp2_q <= gp2_d; p2_q  <= p2_d;  c2_q  <= c2_d;
      am2_q <= am2_d; bm2_q <= bm2_d;
      v3_q  <= v3_d;  d3_q  <= d3_d;  bo3_q <= bo3_d; ov3_q <= ov3_d;
    end
  end

  assign out_valid = v3_q;
  assign D         = d3_q;
  assign Bo        = bo3_q;
  assign V         = ov3_q;

endmodule

// File: tb/tb_ksa_sub_pipe.sv
// tb_ksa_sub_pipe: directed and random checks of ksa_sub_pipe against an
// arithmetic reference model and an in-order scoreboard.
module tb_ksa_sub_pipe;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Bi;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] D;
  logic         Bo;
  logic         V;

  always #5 clk = ~clk;

  ksa_sub_pipe #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bi        (Bi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .Bo        (Bo),
    .V         (V)
  );

  int total   = 0;
  int bad     = 0;
  int acc_cnt = 0;
  int emit_cnt = 0;
  int cyc_n   = 0;
  logic last_irdy;

  // Expected results in acceptance order, packed as {V, Bo, D}.
  logic [N+1:0] exp_q[$];
  // Log of emitted results and the cycle each one left the block.
  logic [N+1:0] emit_val[$];
  int           emit_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {Bo,D} = {0,A} - B - Bi in N+1 bits; V from the sign rule.
  function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic bi);
    logic [N:0] r;
    logic       v;
    r = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bi};
    v = (a[N-1] ^ b[N-1]) & (a[N-1] ^ r[N-1]);
    return {v, r};
  endfunction

  // Drive one cycle's inputs, observe both handshakes just before the
  // edge, update the scoreboard, then move to 1 ns after the edge.
  task automatic cyc(input logic iv, input logic [N-1:0] a, input logic [N-1:0] b,
                     input logic bi, input logic ordy);
    logic [N+1:0] e;
    in_valid  = iv;
    A         = a;
    B         = b;
    Bi        = bi;
    out_ready = ordy;
    #2;
    last_irdy = in_ready;
    if (iv && in_ready) begin
      exp_q.push_back(model(a, b, bi));
      acc_cnt++;
    end
    if (out_valid && out_ready) begin
      emit_cnt++;
      emit_val.push_back({V, Bo, D});
      emit_cyc.push_back(cyc_n);
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_result", 32'({V, Bo, D}), 32'(e));
      end
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [N+1:0] snap;
    int           acc0;
    int           emit0;
    int           target;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    Bi        = 1'b0;

    // Reset state while reset is asserted, then release between edges.
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dbov", 32'({V, Bo, D}), 32'd0);
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Latency: result visible after the third edge, counting the accepting one.
    cyc(1'b1, 16'h0019, 16'h0001, 1'b0, 1'b1);
    check("lat_e1_valid", 32'(out_valid), 32'd0);
    idle(1);
    check("lat_e2_valid", 32'(out_valid), 32'd0);
    idle(1);
    check("lat_e3_valid", 32'(out_valid), 32'd1);
    check("lat_e3_dbov", 32'({V, Bo, D}), 32'({1'b0, 1'b0, 16'h0018}));
    idle(1);
    check("lat_drained", 32'(out_valid), 32'd0);

    // Streaming with out_ready held high.
    emit_val.delete();
    emit_cyc.delete();
    cyc(1'b1, 16'h0001, 16'hFFFF, 1'b1, 1'b1);
    cyc(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1);
    cyc(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1);
    idle(5);
    check("stream_count", 32'(emit_val.size()), 32'd3);
    if (emit_val.size() == 3) begin
      check("stream_r0", 32'(emit_val[0]), 32'({1'b0, 1'b1, 16'h0001}));
      check("stream_r1", 32'(emit_val[1]), 32'({1'b1, 1'b0, 16'h7FFF}));
      check("stream_r2", 32'(emit_val[2]), 32'({1'b0, 1'b1, 16'hFFFF}));
      check("stream_back2back_1", 32'(emit_cyc[1] - emit_cyc[0]), 32'd1);
      check("stream_back2back_2", 32'(emit_cyc[2] - emit_cyc[1]), 32'd1);
    end

    // Equal operands, with and without borrow-in.
    emit_val.delete();
    cyc(1'b1, 16'h5A5A, 16'h5A5A, 1'b0, 1'b1);
    cyc(1'b1, 16'h5A5A, 16'h5A5A, 1'b1, 1'b1);
    idle(4);
    check("eq_count", 32'(emit_val.size()), 32'd2);
    if (emit_val.size() == 2) begin
      check("eq_bi0", 32'(emit_val[0]), 32'({1'b0, 1'b0, 16'h0000}));
      check("eq_bi1", 32'(emit_val[1]), 32'({1'b0, 1'b1, 16'hFFFF}));
    end

    // Backpressure: fill the pipe, stall five cycles, then release.
    emit0 = emit_cnt;
    cyc(1'b1, 16'h1234, 16'h0234, 1'b0, 1'b0);
    cyc(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b0);
    cyc(1'b1, 16'h7FFF, 16'h8000, 1'b0, 1'b0);
    check("bp_full_valid", 32'(out_valid), 32'd1);
    snap = {V, Bo, D};
    acc0 = acc_cnt;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b0);
      check("bp_in_ready_low", 32'(last_irdy), 32'd0);
      check("bp_out_stable", 32'({V, Bo, D}), 32'(snap));
      check("bp_out_valid_held", 32'(out_valid), 32'd1);
    end
    check("bp_no_accept", 32'(acc_cnt - acc0), 32'd0);
    cyc(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b1);
    check("bp_simul_accept", 32'(last_irdy), 32'd1);
    idle(6);
    check("bp_delivered", 32'(emit_cnt - emit0), 32'd4);
    check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with results in flight.
    cyc(1'b1, 16'h00F0, 16'h000F, 1'b0, 1'b0);
    cyc(1'b1, 16'h0F00, 16'h00F0, 1'b0, 1'b0);
    cyc(1'b1, 16'hF000, 16'h0F00, 1'b1, 1'b0);
    in_valid = 1'b0;
    check("mid_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_dbov", 32'({V, Bo, D}), 32'd0);
    exp_q.delete();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_in_ready", 32'(in_ready), 32'd1);
    emit_val.delete();
    idle(6);
    check("mid_no_ghost", 32'(emit_val.size()), 32'd0);

    // Random traffic with random backpressure.
    acc0   = acc_cnt;
    emit0  = emit_cnt;
    target = acc_cnt + 10000;
    for (int c = 0; c < 40000 && acc_cnt < target; c++) begin
      cyc($urandom_range(0, 3) != 0, N'($urandom), N'($urandom),
          1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end
    idle(10);
    check("rnd_accepted", 32'(acc_cnt - acc0), 32'd10000);
    check("rnd_emitted", 32'(emit_cnt - emit0), 32'(acc_cnt - acc0));
    check("rnd_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
